frame_sequencer: RTL and testbench



---
 rtl/frame_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_frame_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Per-frame game-loop sequencer: steps stages over a one-hot enable/done handshake,
// muxes their pixels to one VGA port. Define FRAME_SEQUENCER_STAGE_TIMEOUT_EN for the stage watchdog.
module frame_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int X_W            = 8,
  parameter int Y_W            = 7,
  parameter int C_W            = 9,
  parameter int FRAME_DIV      = 833333,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      Clock,
  input  logic                      resetn,
  input  logic                      run,
  output logic [NUM_STAGES-1:0]     stage_en,
  input  logic [NUM_STAGES-1:0]     stage_done,
  input  logic [NUM_STAGES*X_W-1:0] stage_x,
  input  logic [NUM_STAGES*Y_W-1:0] stage_y,
  input  logic [NUM_STAGES*C_W-1:0] stage_color,
  input  logic [NUM_STAGES-1:0]     stage_plot,
  output logic [X_W-1:0]            x,
  output logic [Y_W-1:0]            y,
  output logic [C_W-1:0]            color,
  output logic                      plot,
  output logic                      move_en,
  output logic [15:0]               frame_cnt,
  output logic                      busy,
  output logic                      overrun,
  output logic                      timeout_err,
  output logic [3:0]                timeout_stage
);

  localparam int DIV_W = $clog2(FRAME_DIV);
  localparam logic [3:0] LAST_IDX = 4'(NUM_STAGES - 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_FRAME = 2'd1;
  localparam logic [1:0] STAGE      = 2'd2;
  localparam logic [1:0] MOVE       = 2'd3;

  if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_num_stages
    $error("frame_sequencer: NUM_STAGES must be in 1..16");
  end
  if (FRAME_DIV < 2) begin : g_bad_frame_div
    $error("frame_sequencer: FRAME_DIV must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("frame_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0]       state;
  logic [3:0]       idx;
  logic             guard;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             tick_pending;
  logic             consume;
  logic             done_sel;
  logic             timeout_hit;
  logic             advance;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [C_W-1:0]   sel_color;
  logic             sel_plot;

  assign tick     = (div_cnt == DIV_W'(FRAME_DIV - 1));
  assign consume  = (state == WAIT_FRAME) && (tick_pending || tick);
  assign done_sel = |(stage_done & stage_en);
  assign advance  = (state == STAGE) && !guard && (done_sel || timeout_hit);
  assign busy     = (state == STAGE) || (state == MOVE);
  assign sel_plot = |(stage_plot & stage_en);

  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // A tick landing in the consume cycle becomes the new pending tick, not an overrun.
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      tick_pending <= 1'b0;
      overrun      <= 1'b0;
    end else if (consume) begin
      tick_pending <= tick_pending && tick;
    end else if (tick) begin
      if (tick_pending) begin
        overrun <= 1'b1;
      end
      tick_pending <= 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      idx       <= 4'd0;
      guard     <= 1'b0;
      stage_en  <= '0;
      move_en   <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (consume) begin
            state    <= STAGE;
            idx      <= 4'd0;
            guard    <= 1'b1;
            stage_en <= NUM_STAGES'(1);
          end
        end
        STAGE: begin
          guard <= 1'b0;
          if (advance) begin
            if (idx == LAST_IDX) begin
              state     <= MOVE;
              stage_en  <= '0;
              move_en   <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
            end else begin
              idx      <= idx + 4'd1;
              guard    <= 1'b1;
              stage_en <= stage_en << 1;
            end
          end
        end
        MOVE: begin
          move_en <= 1'b0;
          state   <= run ? WAIT_FRAME : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_en[i]) begin
        sel_x     = stage_x[i*X_W +: X_W];
        sel_y     = stage_y[i*Y_W +: Y_W];
        sel_color = stage_color[i*C_W +: C_W];
      end
    end
  end

  // Pixels from the exit cycle are dropped so a finished stage never writes late.
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      x     <= '0;
      y     <= '0;
      color <= '0;
      plot  <= 1'b0;
    end else if ((state == STAGE) && !advance) begin
      x     <= sel_x;
      y     <= sel_y;
      color <= sel_color;
      plot  <= sel_plot;
    end else begin
      plot  <= 1'b0;
    end
  end

`ifdef FRAME_SEQUENCER_STAGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      to_cnt <= '0;
    end else if ((state != STAGE) || advance) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // A real done in the expiry cycle wins, so no error is logged then.
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      timeout_err   <= 1'b0;
      timeout_stage <= 4'd0;
    end else if ((state == STAGE) && !guard && !done_sel && timeout_hit) begin
      timeout_err   <= 1'b1;
      timeout_stage <= idx;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign timeout_err   = 1'b0;
  assign timeout_stage = 4'd0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: frame pacing, stage stepping, pixel mux,
// overrun, run drop-out, async reset and (with the macro) the stage watchdog.
module tb_frame_sequencer;

  localparam int NS  = 4;
  localparam int XW  = 8;
  localparam int YW  = 7;
  localparam int CW  = 9;
  localparam int DIV = 10;
  localparam int TO  = 8;

  logic            Clock;
  logic            resetn;
  logic            run;
  logic [NS-1:0]   stage_en;
  logic [NS-1:0]   stage_done;
  logic [NS*XW-1:0] stage_x;
  logic [NS*YW-1:0] stage_y;
  logic [NS*CW-1:0] stage_color;
  logic [NS-1:0]   stage_plot;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   color;
  logic            plot;
  logic            move_en;
  logic [15:0]     frame_cnt;
  logic            busy;
  logic            overrun;
  logic            timeout_err;
  logic [3:0]      timeout_stage;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int base;
  int move2;
  logic [7:0] exp_x [8];
  logic [7:0] exp_plot;
  logic [3:0] exp_en;

  frame_sequencer #(
    .NUM_STAGES(NS), .X_W(XW), .Y_W(YW), .C_W(CW),
    .FRAME_DIV(DIV), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clock(Clock), .resetn(resetn), .run(run),
    .stage_en(stage_en), .stage_done(stage_done),
    .stage_x(stage_x), .stage_y(stage_y), .stage_color(stage_color),
    .stage_plot(stage_plot),
    .x(x), .y(y), .color(color), .plot(plot),
    .move_en(move_en), .frame_cnt(frame_cnt), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err), .timeout_stage(timeout_stage)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic applyStimulus(input logic [3:0] done_v, input logic run_v);
    stage_done = done_v;
    run        = run_v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Cycle k means 1 time unit after the k-th rising edge since reset release.
  task automatic runTo(input int k);
    while (cycle < k) begin
      @(posedge Clock);
      #1;
      cycle++;
    end
  endtask

  initial begin
    exp_x    = '{8'h00, 8'hAA, 8'hAA, 8'h05, 8'h05, 8'h22, 8'h22, 8'h33};
    exp_plot = 8'b0000_1010;
    stage_x     = {8'h33, 8'h22, 8'h05, 8'hAA};
    stage_y     = {7'h33, 7'h22, 7'h07, 7'h11};
    stage_color = {9'h133, 9'h122, 9'h1FF, 9'h055};
    stage_plot  = 4'b0011;
    resetn = 1'b0;
    applyStimulus(4'b1111, 1'b1);

    repeat (3) @(posedge Clock);
    #1;
    checkOutput("rst_stage_en", stage_en, 0);
    checkOutput("rst_plot", plot, 0);
    checkOutput("rst_x", x, 0);
    checkOutput("rst_move_en", move_en, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_timeout_stage", timeout_stage, 0);

    @(negedge Clock);
    resetn = 1'b1;
    cycle  = 0;

    $display("[TB] frame 1: stepping and pixel mux");
    runTo(9);
    checkOutput("f1_pre_tick_en", stage_en, 0);
    checkOutput("f1_pre_tick_busy", busy, 0);
    for (int k = 10; k < 18; k++) begin
      runTo(k);
      exp_en = 4'b0001 << ((k - 10) / 2);
      checkOutput("f1_stage_en", stage_en, exp_en);
      checkOutput("f1_x", x, exp_x[k-10]);
      checkOutput("f1_plot", plot, exp_plot[k-10]);
      if (k == 13) begin
        checkOutput("f1_y_stage1", y, 7'h07);
        checkOutput("f1_color_stage1", color, 9'h1FF);
      end
    end
    runTo(18);
    checkOutput("f1_move_en", move_en, 1);
    checkOutput("f1_frame_cnt", frame_cnt, 1);
    checkOutput("f1_move_stage_en", stage_en, 0);
    checkOutput("f1_move_busy", busy, 1);
    runTo(19);
    checkOutput("f1_move_end", move_en, 0);
    checkOutput("f1_wait_busy", busy, 0);
    `ifdef FRAME_SEQUENCER_STAGE_TIMEOUT_EN
    applyStimulus(4'b1001, 1'b1);
    move2 = 40;
    `else
    applyStimulus(4'b1011, 1'b1);
    move2 = 51;
    `endif
    runTo(20);
    checkOutput("f2_start_en", stage_en, 4'b0001);

    $display("[TB] frame 2: slow stage and overrun");
    runTo(39);
    checkOutput("f2_overrun_before", overrun, 0);
    runTo(40);
    checkOutput("f2_overrun_after", overrun, 1);
    `ifdef FRAME_SEQUENCER_STAGE_TIMEOUT_EN
    runTo(30);
    `else
    runTo(48);
    checkOutput("f2_stage2_held", stage_en, 4'b0100);
    applyStimulus(4'b1111, 1'b1);
    runTo(49);
    checkOutput("f2_stage3_en", stage_en, 4'b1000);
    `endif
    runTo(move2);
    checkOutput("f2_move_en", move_en, 1);
    checkOutput("f2_frame_cnt", frame_cnt, 2);
    applyStimulus(4'b1111, 1'b1);
    runTo(move2 + 1);
    checkOutput("f2_wait_en", stage_en, 0);
    checkOutput("f2_wait_busy", busy, 0);
    runTo(move2 + 2);
    checkOutput("f2_pending_start", stage_en, 4'b0001);
    base = move2 + 2;

    $display("[TB] frame 3: run dropped during stage 2");
    runTo(base + 4);
    checkOutput("f3_stage2_en", stage_en, 4'b0100);
    applyStimulus(4'b1111, 1'b0);
    runTo(base + 6);
    checkOutput("f3_stage3_en", stage_en, 4'b1000);
    runTo(base + 8);
    checkOutput("f3_move_en", move_en, 1);
    checkOutput("f3_frame_cnt", frame_cnt, 3);
    for (int k = base + 9; k <= base + 22; k++) begin
      runTo(k);
      checkOutput("f3_idle_en", stage_en, 0);
      checkOutput("f3_idle_busy", busy, 0);
      checkOutput("f3_idle_move", move_en, 0);
    end
    applyStimulus(4'b1111, 1'b1);
    runTo(base + 24);
    checkOutput("f4_start_en", stage_en, 4'b0001);
    runTo(base + 27);
    checkOutput("f4_stage1_en", stage_en, 4'b0010);
    checkOutput("f4_plot", plot, 1);
    checkOutput("f4_x", x, 8'h05);

    $display("[TB] asynchronous reset during stage 1");
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("arst_stage_en", stage_en, 0);
    checkOutput("arst_plot", plot, 0);
    checkOutput("arst_frame_cnt", frame_cnt, 0);
    checkOutput("arst_overrun", overrun, 0);
    checkOutput("arst_timeout_err", timeout_err, 0);
    checkOutput("arst_busy", busy, 0);
    applyStimulus(4'b1101, 1'b1);
    @(negedge Clock);
    resetn = 1'b1;
    cycle  = 0;

    runTo(1);
    checkOutput("r_wait_busy", busy, 0);
    runTo(9);
    checkOutput("r_pre_tick_en", stage_en, 0);
    runTo(10);
    checkOutput("r_stage0_en", stage_en, 4'b0001);
    runTo(12);
    checkOutput("r_stage1_en", stage_en, 4'b0010);
    checkOutput("r_frame_cnt", frame_cnt, 0);
    runTo(19);
    checkOutput("r_stage1_held", stage_en, 4'b0010);
    checkOutput("r_no_timeout_yet", timeout_err, 0);
    `ifdef FRAME_SEQUENCER_STAGE_TIMEOUT_EN
    runTo(20);
    checkOutput("to_stage2_en", stage_en, 4'b0100);
    checkOutput("to_err", timeout_err, 1);
    checkOutput("to_stage", timeout_stage, 1);
    runTo(24);
    `else
    runTo(20);
    checkOutput("nto_still_waiting", stage_en, 4'b0010);
    checkOutput("nto_err", timeout_err, 0);
    checkOutput("nto_stage", timeout_stage, 0);
    applyStimulus(4'b1111, 1'b1);
    runTo(21);
    checkOutput("nto_stage2_en", stage_en, 4'b0100);
    runTo(25);
    `endif
    checkOutput("r_move_en", move_en, 1);
    checkOutput("r_frame_cnt_done", frame_cnt, 1);
    checkOutput("r_overrun", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
